// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART RX sampling path.
//   sampler_state_e : majority-vote sampler FSM states
//   DefPrescaleW    : default width of prescale / edge counter
//   DefNumSamples   : default number of oversamples per bit
//   IdleLevel       : UART line level when idle (mark)
//   clog2()         : ceiling log2, for deriving counter widths
package uart_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StResolve
  } sampler_state_e;

  localparam int unsigned DefPrescaleW  = 6;
  localparam int unsigned DefNumSamples = 3;
  localparam logic        IdleLevel     = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchroniser for a single asynchronous bit.
//   CLK : clock, rising edge
//   RST : synchronous active-high reset; both flops load ResetVal
//   d_i : asynchronous input
//   q_o : synchronised output, two cycles behind d_i
module bit_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_d, sync_q;

  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/data_sampling_mv.sv
// UART RX bit sampler with majority vote over NUM_SAMPLES oversamples centred
// on the bit midpoint. Non-unanimous windows are flagged as noise, and a
// one-cycle sample_valid strobe marks each resolve.
//   CLK, RST      : clock / synchronous active-high reset
//   rx_in         : serial RX line
//   prescale      : edges per bit (4..63)
//   edge_cnt      : current edge index within the bit
//   enable        : sampling enable from the RX FSM
//   sampled_bit   : majority-resolved bit, held until the next resolve
//   sample_valid  : one-cycle pulse when sampled_bit/noise_err update
//   noise_err     : last window was not unanimous
// Optional: define DATA_SAMPLING_RX_SYNC_EN to pass rx_in through a 2-flop
// synchroniser (reset to the idle line level) before capture.
module data_sampling_mv
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W  = DefPrescaleW,
  parameter int unsigned NUM_SAMPLES = DefNumSamples,
  parameter int unsigned CNT_W       = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic                  enable,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  noise_err
);

  localparam int unsigned WideW   = PRESCALE_W + 1;
  localparam int unsigned HalfWin = (NUM_SAMPLES - 1) / 2;

  // Line value actually captured
  logic rx_s;

`ifdef DATA_SAMPLING_RX_SYNC_EN
  bit_sync2 #(
    .ResetVal(IdleLevel)
  ) u_rx_sync (
    .CLK(CLK),
    .RST(RST),
    .d_i(rx_in),
    .q_o(rx_s)
  );
`else
  assign rx_s = rx_in;
`endif

  // Window arithmetic, one bit wider so underflow/overflow is visible
  logic [WideW-1:0]      half_w, start_raw, end_raw, max_edge;
  logic                  degen;
  logic [PRESCALE_W-1:0] w_start, w_end;
  logic                  in_win;

  always_comb begin
    half_w    = {2'b00, prescale[PRESCALE_W-1:1]};
    start_raw = (half_w >= WideW'(HalfWin)) ? (half_w - WideW'(HalfWin)) : '0;
    end_raw   = start_raw + WideW'(NUM_SAMPLES - 1);
    max_edge  = {1'b0, prescale} - WideW'(1);
    // Window does not fit in the bit: fall back to one sample at the midpoint
    degen     = (end_raw > max_edge);
    w_start   = degen ? half_w[PRESCALE_W-1:0] : start_raw[PRESCALE_W-1:0];
    w_end     = degen ? half_w[PRESCALE_W-1:0] : end_raw[PRESCALE_W-1:0];
    in_win    = (edge_cnt >= w_start) && (edge_cnt <= w_end);
  end

  sampler_state_e        state_d, state_q;
  logic [CNT_W-1:0]      ones_d, ones_q;
  logic [CNT_W-1:0]      idx_d, idx_q;
  logic [PRESCALE_W-1:0] last_edge_d, last_edge_q;
  logic                  bit_d, bit_q;
  logic                  noise_d, noise_q;
  logic                  valid_d, valid_q;

  logic             capture;
  logic [CNT_W-1:0] ones_inc;

  always_comb begin
    state_d     = state_q;
    ones_d      = ones_q;
    idx_d       = idx_q;
    last_edge_d = last_edge_q;
    bit_d       = bit_q;
    noise_d     = noise_q;
    valid_d     = 1'b0;
    capture     = 1'b0;
    ones_inc    = ones_q + CNT_W'(rx_s);

    unique case (state_q)
      StIdle: begin
        if (enable && (edge_cnt == w_start)) begin
          capture = 1'b1;
        end
      end
      StCollect: begin
        if (!enable || !in_win) begin
          // Disabled or counter left the window early: abort, outputs hold
          state_d = StIdle;
          ones_d  = '0;
          idx_d   = '0;
        end else if (edge_cnt != last_edge_q) begin
          capture = 1'b1;
        end
      end
      StResolve: begin
        state_d = StIdle;
        ones_d  = '0;
        idx_d   = '0;
      end
      default: begin
        state_d = StIdle;
        ones_d  = '0;
        idx_d   = '0;
      end
    endcase

    if (capture) begin
      ones_d      = ones_inc;
      idx_d       = idx_q + CNT_W'(1);
      last_edge_d = edge_cnt;
      if (edge_cnt == w_end) begin
        // Outputs register on the last capture so they are valid in RESOLVE
        state_d = StResolve;
        valid_d = 1'b1;
        if (degen) begin
          bit_d   = rx_s;
          noise_d = 1'b0;
        end else begin
          bit_d   = (ones_inc > CNT_W'(NUM_SAMPLES / 2));
          noise_d = (ones_inc != '0) && (ones_inc != CNT_W'(NUM_SAMPLES));
        end
      end else begin
        state_d = StCollect;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      ones_q      <= '0;
      idx_q       <= '0;
      last_edge_q <= '0;
      bit_q       <= 1'b0;
      noise_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      idx_q       <= idx_d;
      last_edge_q <= last_edge_d;
      bit_q       <= bit_d;
      noise_q     <= noise_d;
      valid_q     <= valid_d;
    end
  end

  assign sampled_bit  = bit_q;
  assign sample_valid = valid_q;
  assign noise_err    = noise_q;

endmodule

// File: tb/tb_data_sampling_mv.sv
// Directed bench for data_sampling_mv: a 3-sample and a 5-sample instance
// share stimulus; each step checks the instance the vector was written for.
module tb_data_sampling_mv;

`ifdef DATA_SAMPLING_RX_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  logic       CLK;
  logic       RST;
  logic       rx_in;
  logic [5:0] prescale;
  logic [5:0] edge_cnt;
  logic       enable;
  logic       sb3, sv3, ne3;
  logic       sb5, sv5, ne5;

  data_sampling_mv #(
    .PRESCALE_W (6),
    .NUM_SAMPLES(3),
    .CNT_W      (3)
  ) dut3 (
    .CLK         (CLK),
    .RST         (RST),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .edge_cnt    (edge_cnt),
    .enable      (enable),
    .sampled_bit (sb3),
    .sample_valid(sv3),
    .noise_err   (ne3)
  );

  data_sampling_mv #(
    .PRESCALE_W (6),
    .NUM_SAMPLES(5),
    .CNT_W      (3)
  ) dut5 (
    .CLK         (CLK),
    .RST         (RST),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .edge_cnt    (edge_cnt),
    .enable      (enable),
    .sampled_bit (sb5),
    .sample_valid(sv5),
    .noise_err   (ne5)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int pass_cnt = 0;
  int total    = 0;

  // Stimulus sequence: per cycle edge index, line value at capture, enable
  int   seq_n;
  int   seq_e  [32];
  logic seq_r  [32];
  logic seq_en [32];

  // Observations from the last run_seq
  int   v3_cnt, v3_idx, v5_cnt, v5_idx, v3_back2back;
  logic b3, n3, b5, n5;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic set_bit(input int ps, input logic [63:0] pat);
    prescale = 6'(ps);
    seq_n    = ps;
    for (int e = 0; e < ps; e++) begin
      seq_e[e]  = e;
      seq_r[e]  = pat[e];
      seq_en[e] = 1'b1;
    end
  endtask

  // Drives the line Lat cycles early so the value seen at capture is seq_r[i]
  task automatic run_seq();
    logic prev3;
    v3_cnt = 0; v3_idx = -1; v5_cnt = 0; v5_idx = -1; v3_back2back = 0;
    prev3  = 1'b0;
    for (int i = 0; i < seq_n; i++) begin
      edge_cnt = 6'(seq_e[i]);
      enable   = seq_en[i];
      rx_in    = (i + Lat < seq_n) ? seq_r[i + Lat] : 1'b1;
      @(posedge CLK);
      #1;
      if (sv3) begin
        v3_cnt++; v3_idx = i; b3 = sb3; n3 = ne3;
        if (prev3) v3_back2back++;
      end
      if (sv5) begin
        v5_cnt++; v5_idx = i; b5 = sb5; n5 = ne5;
      end
      prev3 = sv3;
    end
  endtask

  initial begin
    RST = 1'b1; rx_in = 1'b1; prescale = 6'd8; edge_cnt = '0; enable = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_bit3", sb3, 0);
    chk("rst_valid3", sv3, 0);
    chk("rst_noise3", ne3, 0);
    chk("rst_bit5", sb5, 0);
    chk("rst_valid5", sv5, 0);
    chk("rst_noise5", ne5, 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // N=3, prescale 8, window 3..5, all ones
    set_bit(8, 64'h38);
    run_seq();
    chk("t1_vcnt", v3_cnt, 1);
    chk("t1_vidx", v3_idx, 5);
    chk("t1_bit", b3, 1);
    chk("t1_noise", n3, 0);
    chk("t1_b2b", v3_back2back, 0);

    // 1,0,1
    set_bit(8, 64'h28);
    run_seq();
    chk("t2_vcnt", v3_cnt, 1);
    chk("t2_bit", b3, 1);
    chk("t2_noise", n3, 1);

    // 0,0,1
    set_bit(8, 64'h20);
    run_seq();
    chk("t3_vidx", v3_idx, 5);
    chk("t3_bit", b3, 0);
    chk("t3_noise", n3, 1);

    // Enable dropped at edge 4: no strobe, outputs keep 0/1
    set_bit(8, 64'h38);
    seq_en[4] = 1'b0;
    run_seq();
    chk("en_drop_vcnt", v3_cnt, 0);
    chk("en_drop_bit", sb3, 0);
    chk("en_drop_noise", ne3, 1);

    // Next full window resolves normally
    set_bit(8, 64'h38);
    run_seq();
    chk("after_drop_vidx", v3_idx, 5);
    chk("after_drop_bit", b3, 1);
    chk("after_drop_noise", n3, 0);

    // All zeros
    set_bit(8, 64'h00);
    run_seq();
    chk("zeros_bit", b3, 0);
    chk("zeros_noise", n3, 0);

    // Repeated edge 4 must be ignored: 0,1,(1),0 -> ones=1
    prescale = 6'd8;
    seq_n = 9;
    for (int i = 0; i < 9; i++) begin
      seq_e[i] = (i <= 4) ? i : i - 1;
      seq_r[i] = 1'b0;
      seq_en[i] = 1'b1;
    end
    seq_r[4] = 1'b1;
    seq_r[5] = 1'b1;
    run_seq();
    chk("rep_vcnt", v3_cnt, 1);
    chk("rep_vidx", v3_idx, 6);
    chk("rep_bit", b3, 0);
    chk("rep_noise", n3, 1);

    // Counter restarts before w_end: abort, outputs hold 0/1
    seq_n = 8;
    for (int i = 0; i < 8; i++) begin
      seq_e[i] = (i <= 4) ? i : i - 5;
      seq_r[i] = 1'b1;
      seq_en[i] = 1'b1;
    end
    run_seq();
    chk("abort_vcnt", v3_cnt, 0);
    chk("abort_bit", sb3, 0);
    chk("abort_noise", ne3, 1);

    // N=5, prescale 16, window 6..10: 0,1,1,0,1
    set_bit(16, 64'h580);
    run_seq();
    chk("n5_vcnt", v5_cnt, 1);
    chk("n5_vidx", v5_idx, 10);
    chk("n5_bit", b5, 1);
    chk("n5_noise", n5, 1);

    // N=5, prescale 4: degenerate, single sample at edge 2
    set_bit(4, 64'hB);
    run_seq();
    chk("deg0_vidx", v5_idx, 2);
    chk("deg0_bit", b5, 0);
    chk("deg0_noise", n5, 0);
    set_bit(4, 64'h4);
    run_seq();
    chk("deg1_vcnt", v5_cnt, 1);
    chk("deg1_bit", b5, 1);
    chk("deg1_noise", n5, 0);

    // Leave N=3 outputs at 0/1, then reset in the middle of a window
    set_bit(8, 64'h20);
    run_seq();
    chk("pre_rst_noise", n3, 1);
    set_bit(8, 64'h38);
    seq_n = 5;
    run_seq();
    RST = 1'b1; edge_cnt = 6'd5; enable = 1'b1; rx_in = 1'b1;
    @(posedge CLK); #1;
    chk("mid_rst_valid", sv3, 0);
    chk("mid_rst_bit", sb3, 0);
    chk("mid_rst_noise", ne3, 0);
    RST = 1'b0;
    set_bit(8, 64'h38);
    run_seq();
    chk("post_rst_vidx", v3_idx, 5);
    chk("post_rst_bit", b3, 1);
    chk("post_rst_noise", n3, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/data_sampling_mv.md
Name: data_sampling_mv

Overview:
- Parametrised successor of the UART RX bit sampler.
- Captures NUM_SAMPLES oversampled copies of the RX line in a window centred on the bit midpoint.
- Resolves the bit by majority vote and flags non-unanimous windows as noise.
- Sits between the RX edge/bit counter and the RX FSM; adds a one-cycle valid strobe so the FSM no longer infers sample timing.

Parameters:
- PRESCALE_W, 6, width of prescale and edge_cnt.
- NUM_SAMPLES, 3, samples per bit; odd, 1..7.
- CNT_W, 3, width of the ones counter; must hold NUM_SAMPLES.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- rx_in  in  1  serial RX line.
- prescale  in  PRESCALE_W  oversampling ratio (edges per bit), 4..63.
- edge_cnt  in  PRESCALE_W  current edge index within the bit, 0..prescale-1.
- enable  in  1  sampling enabled (driven by RX FSM).
- sampled_bit  out  1  majority-resolved bit; held until the next resolve.
- sample_valid  out  1  one-cycle pulse: sampled_bit and noise_err updated this cycle.
- noise_err  out  1  last window not unanimous; held with sampled_bit.

Behaviour:
- Reset (RST=1 at CLK edge): state=IDLE, ones count=0, sample index=0, sampled_bit=0, sample_valid=0, noise_err=0.
- Window arithmetic is unsigned, full PRESCALE_W bits; no truncation of edge_cnt.
  - half = prescale>>1.
  - w_start = half - (NUM_SAMPLES-1)/2, clamped to 0 on underflow.
  - w_end = w_start + NUM_SAMPLES - 1.
- Degenerate window: if w_end > prescale-1, the window collapses to a single sample at half.
  - In this case the majority equals that sample and noise_err=0.
- FSM states and transitions:
  - IDLE -> COLLECT when enable=1 and edge_cnt==w_start.
    - The sample at w_start is captured in that same cycle.
  - COLLECT: each cycle with edge_cnt in [w_start..w_end] and enable=1, capture rx_in.
    - ones += rx_in; index += 1.
    - On the capture at edge_cnt==w_end, go to RESOLVE.
  - RESOLVE (one cycle):
    - sampled_bit <= (ones > NUM_SAMPLES/2).
    - noise_err <= (ones != 0 && ones != NUM_SAMPLES).
    - sample_valid=1.
    - Clear ones and index.
    - -> IDLE.
- Latency: sample_valid high exactly one cycle after the cycle with edge_cnt==w_end.
- Only one capture per edge_cnt value; repeated edge_cnt values (prescale held) are ignored.
- edge_cnt leaving the window before w_end (counter reset by FSM): abort to IDLE.
  - Clear the count; no sample_valid; outputs keep their previous values.
- enable deasserted in any state: next cycle state=IDLE, count cleared, sample_valid=0.
  - sampled_bit and noise_err hold.
- enable deasserted in the RESOLVE cycle: the resolve still completes (pulse issued), then IDLE.
- prescale changed mid-window: window recomputed combinationally; behaviour defined only at bit boundaries; the RX FSM guarantees stability.
- sample_valid is never high on two consecutive cycles.

Optional Feature:
- Macro: DATA_SAMPLING_RX_SYNC_EN.
- Defined:
  - rx_in passes through a 2-flop synchroniser (reset to 1, idle line) before capture.
  - Captured values are rx_in as of two cycles earlier; window indices unchanged.
  - Reset value of synchroniser flops = 1.
- Undefined: rx_in captured directly; no extra flops.

Decomposition:
- Package uart_rx_pkg holds:
  - sampler state enum (IDLE, COLLECT, RESOLVE);
  - default PRESCALE_W, NUM_SAMPLES;
  - function clog2 for CNT_W derivation;
  - IDLE line level constant.
- One natural sub-module: bit_sync2 (2-flop synchroniser, CLK/RST, reset value parameter), instantiated only under DATA_SAMPLING_RX_SYNC_EN.

Test Plan:
- NUM_SAMPLES=3, prescale=8, rx_in=1 at edges 3,4,5 -> sample_valid pulse one cycle after edge 5; sampled_bit=1, noise_err=0.
- prescale=8, rx_in=1,0,1 at edges 3,4,5 -> sampled_bit=1, noise_err=1; with 0,0,1 -> sampled_bit=0, noise_err=1.
- NUM_SAMPLES=5, prescale=16, window edges 6..10, rx_in=0,1,1,0,1 -> sampled_bit=1, noise_err=1, valid one cycle after edge 10.
- NUM_SAMPLES=5, prescale=4 -> single sample at edge 2; rx_in=0 -> sampled_bit=0, noise_err=0.
- enable dropped at edge 4 (prescale=8) -> no sample_valid; outputs hold; next full window resolves normally.
- RST=1 asserted mid-COLLECT -> next cycle all outputs 0, state IDLE; with DATA_SAMPLING_RX_SYNC_EN, a rx_in step reaches the ones count 2 cycles later.
